// File: rtl/hs_ram_arbiter.sv
// Arbitrates one single-port work RAM between the Z80 bus and the hiscore engine.
// The CPU is frozen, allowed to settle, then the engine gets single-outstanding access.
module hs_ram_arbiter #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 8,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned RAM_LAT  = 1,
  parameter int unsigned REL_IDLE = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          cpu_ce,
  input  logic          cpu_mreq,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_dout,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_hold,
  input  logic          hs_req,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_wdata,
  output logic [DW-1:0] hs_rdata,
  output logic          hs_ack,
  output logic          hs_granted,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  typedef enum logic [2:0] {
    S_CPU,
    S_HOLD_WAIT,
    S_GRANT,
    S_BUSY,
    S_RELEASE
  } state_t;

  localparam logic [7:0] SETTLE_C   = 8'(SETTLE);
  localparam logic [7:0] RAM_LAT_C  = 8'(RAM_LAT);
  localparam logic [7:0] REL_IDLE_C = 8'(REL_IDLE);

  state_t        state_q, state_d;
  logic [7:0]    settle_q, settle_d;
  logic [7:0]    idle_q, idle_d;
  logic [7:0]    lat_q, lat_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] cpu_din_q, cpu_din_d;
  logic          mux_hs;

  // Mux select derives only from the registered state, so it never glitches mid-cycle.
  assign mux_hs = (state_q == S_GRANT) || (state_q == S_BUSY);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_CPU;
      settle_q  <= '0;
      idle_q    <= '0;
      lat_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      cpu_din_q <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      idle_q    <= idle_d;
      lat_q     <= lat_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      cpu_din_q <= cpu_din_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    idle_d    = idle_q;
    lat_d     = lat_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    cpu_din_d = mux_hs ? cpu_din_q : ram_q;

    case (state_q)
      S_CPU: begin
        settle_d = '0;
        idle_d   = '0;
        if (hs_req) state_d = S_HOLD_WAIT;
      end
      S_HOLD_WAIT: begin
        if (cpu_ce) begin
          if (cpu_mreq)                  settle_d = '0;
          else if (settle_q != SETTLE_C) settle_d = settle_q + 8'd1;
        end
        if (!hs_req) begin
          state_d = S_RELEASE;
        end else if (settle_d == SETTLE_C) begin
          state_d = S_GRANT;
          idle_d  = '0;
        end
      end
      S_GRANT: begin
        // The engine still holds hs_req during the ack cycle; that is not a new request.
        if (hs_req && !ack_q) begin
          we_d    = hs_we;
          addr_d  = hs_addr;
          wdata_d = hs_wdata;
          lat_d   = '0;
          idle_d  = '0;
          state_d = S_BUSY;
        end else if (!hs_req) begin
          if (idle_q != REL_IDLE_C) idle_d = idle_q + 8'd1;
          if (idle_d == REL_IDLE_C) state_d = S_RELEASE;
        end
      end
      S_BUSY: begin
        if (we_q) begin
          ack_d   = 1'b1;
          state_d = S_GRANT;
        end else if (lat_q == RAM_LAT_C) begin
          rdata_d = ram_q;
          ack_d   = 1'b1;
          state_d = S_GRANT;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      S_RELEASE: state_d = S_CPU;
      default:   state_d = S_CPU;
    endcase
  end

  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_dout;
    ram_we    = cpu_mreq & cpu_we;
    if (state_q == S_BUSY) begin
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      ram_we    = we_q;
    end else if (state_q == S_GRANT) begin
      ram_addr  = hs_addr;
      ram_wdata = hs_wdata;
      ram_we    = 1'b0;
    end
    if (!reset_n) ram_we = 1'b0;
  end

  assign cpu_hold   = (state_q != S_CPU);
  assign hs_granted = mux_hs;
  assign hs_ack     = ack_q;
  assign hs_rdata   = rdata_q;
  assign cpu_din    = cpu_din_q;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_hs_ram_arbiter;

  logic        clk_sys;
  logic        reset_n;
  logic        cpu_ce;
  logic        cpu_mreq;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_hold;
  logic        hs_req;
  logic        hs_we;
  logic [15:0] hs_addr;
  logic [7:0]  hs_wdata;
  logic [7:0]  hs_rdata;
  logic        hs_ack;
  logic        hs_granted;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_q;

  logic [7:0]  mem [0:65535];
  int          vectors;
  int          miscompares;

  hs_ram_arbiter #(
    .AW(16), .DW(8), .SETTLE(2), .RAM_LAT(1), .REL_IDLE(4)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cpu_ce(cpu_ce), .cpu_mreq(cpu_mreq),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_hold(cpu_hold), .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr),
    .hs_wdata(hs_wdata), .hs_rdata(hs_rdata), .hs_ack(hs_ack), .hs_granted(hs_granted),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // RAM model; the preload of 0x6100 happens while reset is held.
  always @(posedge clk_sys) begin
    if (!reset_n) mem[16'h6100] <= 8'hA7;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL rst_hold got=%0h exp=0", cpu_hold); end
    vectors++; if (hs_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack got=%0h exp=0", hs_ack); end
    vectors++; if (hs_granted !== 1'b0) begin miscompares++; $display("FAIL rst_granted got=%0h exp=0", hs_granted); end
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL rst_ram_we got=%0h exp=0", ram_we); end
    vectors++; if (hs_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_rdata got=%0h exp=00", hs_rdata); end
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_idle();
    cpu_mreq = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h6000; cpu_dout = 8'h5A;
    #1;
    vectors++; if (ram_we !== 1'b1) begin miscompares++; $display("FAIL t1_we got=%0h exp=1", ram_we); end
    vectors++; if (ram_addr !== 16'h6000) begin miscompares++; $display("FAIL t1_addr got=%0h exp=6000", ram_addr); end
    vectors++; if (ram_wdata !== 8'h5A) begin miscompares++; $display("FAIL t1_wdata got=%0h exp=5a", ram_wdata); end
    step();
    cpu_mreq = 1'b0; cpu_we = 1'b0;
    #1;
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL t1_we_drop got=%0h exp=0", ram_we); end
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL t1_hold got=%0h exp=0", cpu_hold); end
    vectors++; if (mem[16'h6000] !== 8'h5A) begin miscompares++; $display("FAIL t1_mem got=%0h exp=5a", mem[16'h6000]); end
    cpu_mreq = 1'b1;
    step(); step();
    vectors++; if (cpu_din !== 8'h5A) begin miscompares++; $display("FAIL t1_cpu_din got=%0h exp=5a", cpu_din); end
    cpu_mreq = 1'b0;
  endtask

  task automatic test_grant_read();
    hs_req = 1'b1; hs_we = 1'b0; hs_addr = 16'h6100; hs_wdata = 8'h00;
    cpu_mreq = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    step();
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL t2_hold_wait got=%0h exp=1", cpu_hold); end
    for (int i = 0; i < 4; i++) begin
      cpu_ce = 1'b1; step(); cpu_ce = 1'b0; step(); step();
    end
    vectors++; if (hs_granted !== 1'b0) begin miscompares++; $display("FAIL t2_busy_nogrant got=%0h exp=0", hs_granted); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL t2_busy_hold got=%0h exp=1", cpu_hold); end
    cpu_mreq = 1'b0;
    cpu_ce = 1'b1; step(); cpu_ce = 1'b0; step(); step();
    vectors++; if (hs_granted !== 1'b0) begin miscompares++; $display("FAIL t2_one_ce got=%0h exp=0", hs_granted); end
    cpu_ce = 1'b1; step(); cpu_ce = 1'b0;
    #1;
    vectors++; if (hs_granted !== 1'b1) begin miscompares++; $display("FAIL t2_grant got=%0h exp=1", hs_granted); end
    vectors++; if (ram_addr !== 16'h6100) begin miscompares++; $display("FAIL t2_mux got=%0h exp=6100", ram_addr); end
    step();
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL t3_issue_we got=%0h exp=0", ram_we); end
    vectors++; if (hs_ack !== 1'b0) begin miscompares++; $display("FAIL t3_ack_early0 got=%0h exp=0", hs_ack); end
    step();
    vectors++; if (hs_ack !== 1'b0) begin miscompares++; $display("FAIL t3_ack_early1 got=%0h exp=0", hs_ack); end
    step();
    vectors++; if (hs_ack !== 1'b1) begin miscompares++; $display("FAIL t3_ack got=%0h exp=1", hs_ack); end
    vectors++; if (hs_rdata !== 8'hA7) begin miscompares++; $display("FAIL t3_rdata got=%0h exp=a7", hs_rdata); end
    hs_req = 1'b0;
    step();
    vectors++; if (hs_ack !== 1'b0) begin miscompares++; $display("FAIL t3_ack_pulse got=%0h exp=0", hs_ack); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL t3_hold got=%0h exp=1", cpu_hold); end
  endtask

  task automatic test_write_burst();
    logic [7:0] wd [0:2];
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      hs_req = 1'b1; hs_we = 1'b1; hs_addr = 16'h6200 + 16'(i); hs_wdata = wd[i];
      step();
      vectors++; if (ram_we !== 1'b1) begin miscompares++; $display("FAIL t4_we%0d got=%0h exp=1", i, ram_we); end
      vectors++; if (ram_addr !== 16'h6200 + 16'(i)) begin miscompares++; $display("FAIL t4_addr%0d got=%0h exp=%0h", i, ram_addr, 16'h6200 + 16'(i)); end
      vectors++; if (ram_wdata !== wd[i]) begin miscompares++; $display("FAIL t4_wdata%0d got=%0h exp=%0h", i, ram_wdata, wd[i]); end
      step();
      vectors++; if (hs_ack !== 1'b1) begin miscompares++; $display("FAIL t4_ack%0d got=%0h exp=1", i, hs_ack); end
      vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL t4_we_one%0d got=%0h exp=0", i, ram_we); end
      hs_req = 1'b0;
      step();
      vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL t4_hold%0d got=%0h exp=1", i, cpu_hold); end
    end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (mem[16'h6200 + 16'(i)] !== wd[i]) begin miscompares++; $display("FAIL t4_mem%0d got=%0h exp=%0h", i, mem[16'h6200 + 16'(i)], wd[i]); end
    end
    hs_req = 1'b1; hs_we = 1'b0; hs_addr = 16'h6201;
    step(); step(); step();
    vectors++; if (hs_ack !== 1'b1) begin miscompares++; $display("FAIL t4_rb_ack got=%0h exp=1", hs_ack); end
    vectors++; if (hs_rdata !== 8'h22) begin miscompares++; $display("FAIL t4_rb_data got=%0h exp=22", hs_rdata); end
    hs_req = 1'b0;
  endtask

  task automatic test_release();
    step(); step(); step();
    vectors++; if (hs_granted !== 1'b1) begin miscompares++; $display("FAIL t5_still_grant got=%0h exp=1", hs_granted); end
    step();
    vectors++; if (hs_granted !== 1'b0) begin miscompares++; $display("FAIL t5_release_granted got=%0h exp=0", hs_granted); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL t5_release_hold got=%0h exp=1", cpu_hold); end
    step();
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL t5_hold_drop got=%0h exp=0", cpu_hold); end
    cpu_mreq = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h6201;
    #1;
    vectors++; if (ram_addr !== 16'h6201) begin miscompares++; $display("FAIL t5_mux_cpu got=%0h exp=6201", ram_addr); end
    step(); step();
    vectors++; if (cpu_din !== 8'h22) begin miscompares++; $display("FAIL t5_cpu_din got=%0h exp=22", cpu_din); end
    cpu_mreq = 1'b0;
  endtask

  task automatic test_abort();
    hs_req = 1'b1; hs_we = 1'b0; hs_addr = 16'h6100;
    cpu_mreq = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h6300; cpu_dout = 8'h3C;
    #1;
    vectors++; if (ram_we !== 1'b1) begin miscompares++; $display("FAIL ab_cpu_we got=%0h exp=1", ram_we); end
    vectors++; if (ram_addr !== 16'h6300) begin miscompares++; $display("FAIL ab_cpu_addr got=%0h exp=6300", ram_addr); end
    step();
    cpu_mreq = 1'b0; cpu_we = 1'b0; hs_req = 1'b0;
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL ab_hold got=%0h exp=1", cpu_hold); end
    vectors++; if (mem[16'h6300] !== 8'h3C) begin miscompares++; $display("FAIL ab_mem got=%0h exp=3c", mem[16'h6300]); end
    step();
    vectors++; if (cpu_hold !== 1'b1 || hs_granted !== 1'b0) begin miscompares++; $display("FAIL ab_release got=%0h%0h exp=10", cpu_hold, hs_granted); end
    step();
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL ab_cpu got=%0h exp=0", cpu_hold); end
  endtask

  task automatic test_reset_mid_busy();
    hs_req = 1'b1; hs_we = 1'b0; hs_addr = 16'h6100;
    step();
    cpu_ce = 1'b1; step(); step(); cpu_ce = 1'b0;
    vectors++; if (hs_granted !== 1'b1) begin miscompares++; $display("FAIL t6_grant got=%0h exp=1", hs_granted); end
    step();
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL t6_busy_hold got=%0h exp=1", cpu_hold); end
    #1 reset_n = 1'b0;
    #1;
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL t6_hold got=%0h exp=0", cpu_hold); end
    vectors++; if (hs_ack !== 1'b0) begin miscompares++; $display("FAIL t6_ack got=%0h exp=0", hs_ack); end
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL t6_ram_we got=%0h exp=0", ram_we); end
    vectors++; if (hs_granted !== 1'b0) begin miscompares++; $display("FAIL t6_granted got=%0h exp=0", hs_granted); end
    vectors++; if (hs_rdata !== 8'h00) begin miscompares++; $display("FAIL t6_rdata got=%0h exp=00", hs_rdata); end
    hs_req = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    vectors++; if (cpu_hold !== 1'b0 || hs_granted !== 1'b0) begin miscompares++; $display("FAIL t6_after got=%0h%0h exp=00", cpu_hold, hs_granted); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset_n = 1'b0; cpu_ce = 1'b0; cpu_mreq = 1'b0; cpu_we = 1'b0;
    cpu_addr = 16'h0000; cpu_dout = 8'h00;
    hs_req = 1'b0; hs_we = 1'b0; hs_addr = 16'h0000; hs_wdata = 8'h00;
    test_reset();
    test_idle();
    test_grant_read();
    test_write_burst();
    test_release();
    test_abort();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
